// File: rtl/dsp_fetch.sv
// Instruction fetch: owns the PC, reads a 1-cycle synchronous imem, registers the word for decode.
// Latency: a word reaches decode 2 cycles after its read issues; redirect costs 2 empty cycles.
// Backpressure: stall holds the outputs and stops reads; a 1-entry skid catches the word in flight.
module dsp_fetch #(
    parameter int                  INST_WORD_LEN = 32,
    parameter int                  PC_WIDTH      = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     redirect_en,
    input  logic [PC_WIDTH-1:0]      redirect_addr,
    output logic [PC_WIDTH-1:0]      imem_addr,
    output logic                     imem_rd_en,
    input  logic [INST_WORD_LEN-1:0] imem_rdata,
    output logic [INST_WORD_LEN-1:0] instruction,
    output logic [PC_WIDTH-1:0]      inst_pc,
    output logic                     inst_valid
);

    logic [PC_WIDTH-1:0]      pc_q;
    logic [PC_WIDTH-1:0]      req_pc_q;
    logic                     req_valid_q;
    logic                     skid_valid;
    logic [INST_WORD_LEN-1:0] skid_inst;
    logic [PC_WIDTH-1:0]      skid_pc;
    logic                     issue;

    // rst is folded in so the strobe drops the instant reset asserts, not at the next edge.
    assign issue      = !rst && !stall && !redirect_en;
    assign imem_rd_en = issue;
    assign imem_addr  = pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
        end else if (redirect_en) begin
            pc_q        <= redirect_addr;
            req_valid_q <= 1'b0;
        end else if (!stall) begin
            req_valid_q <= 1'b1;
            req_pc_q    <= pc_q;
            pc_q        <= pc_q + PC_WIDTH'(1);
        end else begin
            req_valid_q <= 1'b0;
        end
    end

    // Read data only exists for one cycle, so under stall it is parked in the skid and
    // replayed ahead of anything newer once decode accepts again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid  <= 1'b0;
            skid_inst   <= '0;
            skid_pc     <= '0;
            instruction <= '0;
            inst_pc     <= '0;
            inst_valid  <= 1'b0;
        end else if (redirect_en) begin
            inst_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (stall) begin
            if (req_valid_q) begin
                skid_valid <= 1'b1;
                skid_inst  <= imem_rdata;
                skid_pc    <= req_pc_q;
            end
        end else if (skid_valid) begin
            instruction <= skid_inst;
            inst_pc     <= skid_pc;
            inst_valid  <= 1'b1;
            skid_valid  <= 1'b0;
        end else if (req_valid_q) begin
            instruction <= imem_rdata;
            inst_pc     <= req_pc_q;
            inst_valid  <= 1'b1;
        end else begin
            inst_valid <= 1'b0;
        end
    end

endmodule
